// File: rtl/axis_pixel_streamer_pkg.sv
// Shared constants for the pixel streamer slice.
// NetDataWidth matches the network datapath; L1InputCount is the layer-1
// input (weight) count, so one streamed frame feeds exactly one inference.
package axis_pixel_streamer_pkg;

  localparam int unsigned NetDataWidth = 16;
  localparam int unsigned L1InputCount = 784;
  localparam int unsigned PixAddrWidth = $clog2(L1InputCount);

endpackage

// File: rtl/axis_pixel_streamer_frame_ram.sv
// pix_frame_ram: single-port synchronous frame buffer, write-first, 1-cycle read.
// Written in the plain inferable form so synthesis maps it onto block RAM.
// Ports:
//   s_axi_aclk  clock
//   en          port enable (read or write)
//   we          write enable (qualified by en)
//   addr        shared read/write address
//   wdata       write data
//   rdata       registered read data; holds its value while en is low
module pix_frame_ram
  import axis_pixel_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NetDataWidth,
  parameter int unsigned DEPTH      = L1InputCount,
  parameter int unsigned ADDR_WIDTH = PixAddrWidth
) (
  input  logic                  s_axi_aclk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge s_axi_aclk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axis_pixel_streamer.sv
// axis_pixel_streamer: frame-buffered AXI-Stream pixel source.
// A loader fills the frame buffer through the wr_* port while idle; start
// streams NUM_PIXELS samples in address order, then done pulses for one cycle.
// Optional feature: define PIX_STREAM_TLAST_EN to add the m_axis_last port.
// Ports:
//   s_axi_aclk, reset        clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    buffer write port (accepted only when idle, in range)
//   wr_err                   one-cycle pulse, the cycle after a dropped write
//   start                    frame start request (ignored unless idle)
//   busy                     high while the frame is streaming
//   done                     one-cycle pulse after the final beat
//   m_axis_data/valid/ready  AXI-Stream master
//   m_axis_last              final-beat marker (PIX_STREAM_TLAST_EN only)
module axis_pixel_streamer
  import axis_pixel_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NetDataWidth,
  parameter int unsigned NUM_PIXELS = L1InputCount,
  parameter int unsigned ADDR_WIDTH = PixAddrWidth
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready
`ifdef PIX_STREAM_TLAST_EN
  ,
  output logic                  m_axis_last
`endif
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  rd_fin_q, rd_fin_d;     // read of LastIdx already issued
  logic [ADDR_WIDTH-1:0] beat_cnt_q, beat_cnt_d; // index of the beat at the head
  logic                  ram_vld_q, ram_vld_d;   // RAM output holds an unsent beat
  logic                  skid_vld_q, skid_vld_d; // skid holds an older unsent beat
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  wr_err_q, wr_err_d;

  logic                  out_valid, pop, rem_skid, rem_ram, rd_en, wr_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;

  // 32-bit compare so a NUM_PIXELS equal to 2^ADDR_WIDTH does not truncate
  assign wr_ok    = wr_en && (state_q == StIdle) && (32'(wr_addr) < NUM_PIXELS);
  assign wr_err_d = wr_en && !wr_ok;
  assign ram_addr = (state_q == StIdle) ? wr_addr : rd_ptr_q;

  pix_frame_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_PIXELS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .s_axi_aclk (s_axi_aclk),
    .en         (rd_en || wr_ok),
    .we         (wr_ok),
    .addr       (ram_addr),
    .wdata      (wr_data),
    .rdata      (ram_rdata)
  );

  // Two-entry output queue: the skid register (older) and the RAM output
  // register (newer). The head is the skid entry when present.
  assign out_valid = skid_vld_q || ram_vld_q;
  assign pop       = out_valid && m_axis_ready;
  assign rem_skid  = skid_vld_q && !pop;
  assign rem_ram   = ram_vld_q && !(pop && !skid_vld_q);
  // A new read overwrites the RAM output, so it is only issued when at most one
  // entry survives this cycle; a surviving RAM entry is then moved to the skid.
  assign rd_en     = (state_q == StStream) && !rd_fin_q && !(rem_skid && rem_ram);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_fin_d   = rd_fin_q;
    beat_cnt_d = beat_cnt_q;
    ram_vld_d  = rem_ram;
    skid_vld_d = rem_skid;
    skid_d     = skid_q;

    if (rd_en) begin
      ram_vld_d = 1'b1;
      if (rem_ram) begin
        skid_vld_d = 1'b1;
        skid_d     = ram_rdata;
      end
      if (rd_ptr_q == LastIdx) begin
        rd_fin_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (pop) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StStream;
          rd_ptr_d   = '0;
          rd_fin_d   = 1'b0;
          beat_cnt_d = '0;
          ram_vld_d  = 1'b0;
          skid_vld_d = 1'b0;
        end
      end
      StStream: begin
        if (pop && (beat_cnt_q == LastIdx)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      rd_fin_q   <= 1'b0;
      beat_cnt_q <= '0;
      ram_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_fin_q   <= rd_fin_d;
      beat_cnt_q <= beat_cnt_d;
      ram_vld_q  <= ram_vld_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // RAM output is not reset, so mask it until it carries a beat
  always_comb begin
    m_axis_data = '0;
    if (skid_vld_q) begin
      m_axis_data = skid_q;
    end else if (ram_vld_q) begin
      m_axis_data = ram_rdata;
    end
  end

  assign m_axis_valid = out_valid;
  assign busy         = (state_q == StStream);
  assign done         = (state_q == StDone);
  assign wr_err       = wr_err_q;

`ifdef PIX_STREAM_TLAST_EN
  assign m_axis_last = out_valid && (beat_cnt_q == LastIdx);
`endif

endmodule

// File: tb/tb_axis_pixel_streamer.sv
// Self-checking bench for axis_pixel_streamer. A frame model (array of
// expected samples, updated only by legal writes) predicts every beat.
module tb_axis_pixel_streamer;

  localparam int N  = 784;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          s_axi_aclk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, wr_err;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready = 1'b0;
`ifdef PIX_STREAM_TLAST_EN
  logic          m_axis_last;
`endif

  logic [DW-1:0] model_mem [N];
  int checks   = 0;
  int failures = 0;

  axis_pixel_streamer dut (
    .s_axi_aclk   (s_axi_aclk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .wr_err       (wr_err),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready)
`ifdef PIX_STREAM_TLAST_EN
    ,
    .m_axis_last  (m_axis_last)
`endif
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write, then check the wr_err response on the following cycle.
  // The model follows the rule: only in-range writes while idle land.
  task automatic write_word(input int addr, input logic [DW-1:0] data, input bit exp_err);
    @(negedge s_axi_aclk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    if (!exp_err && addr < N) model_mem[addr] = data;
    @(negedge s_axi_aclk);
    wr_en = 1'b0;
    chk("wr_err", 32'(wr_err), 32'(exp_err));
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready
  // kind: 0 none, 1 bad write to addr 5, 2 second start, 3 reset; fired at beat 'at'
  task automatic run_frame(input int mode, input int kind, input int at, input bit co_write);
    int          beats = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_hs = -10;
    bit          prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit          fired = 0;
    bit          err_due = 0;
    bit          rst_due = 0;
    bit          aborted = 0;
    int          caddr;
    @(negedge s_axi_aclk);
    start = 1'b1;
    if (co_write) begin
      caddr   = int'($urandom_range(N - 1));
      wr_en   = 1'b1;
      wr_addr = AW'(caddr);
      wr_data = DW'($urandom);
      model_mem[caddr] = wr_data;
    end
    @(negedge s_axi_aclk);
    start = 1'b0;
    wr_en = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_first_cycle", 32'(m_axis_valid), 32'd0);
    if (co_write) chk("wr_err_co_write", 32'(wr_err), 32'd0);
    while (done_cnt == 0 && !aborted && cyc < 8000) begin
      case (mode)
        0:       m_axis_ready = 1'b1;
        1:       m_axis_ready = (cyc % 2) == 0;
        default: m_axis_ready = $urandom_range(3) != 0;
      endcase
      start = 1'b0;
      wr_en = 1'b0;
      if (err_due) begin
        chk("wr_err_busy", 32'(wr_err), 32'd1);
        err_due = 0;
      end
      if (rst_due) begin
        reset = 1'b0;
        chk("rst_valid", 32'(m_axis_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(m_axis_data), 32'd0);
        aborted = 1;
      end else if (done) begin
        done_cnt++;
        chk("done_after_last_hs", cyc, last_hs + 1);
        chk("beats_at_done", beats, N);
        chk("busy_at_done", 32'(busy), 32'd0);
        if (mode == 0) chk("done_cycle", cyc, N + 2);
      end else begin
        chk("busy_streaming", 32'(busy), 32'd1);
        if (prev_stall) begin
          chk("stall_valid_hold", 32'(m_axis_valid), 32'd1);
          chk("stall_data_hold", 32'(m_axis_data), 32'(prev_data));
        end
        if (m_axis_valid && beats < N) begin
`ifdef PIX_STREAM_TLAST_EN
          chk("last_flag", 32'(m_axis_last), 32'(beats == N - 1));
`endif
          if (m_axis_ready) begin
            chk("beat_data", 32'(m_axis_data), 32'(model_mem[beats]));
            if (mode == 0) chk("beat_cycle", cyc, beats + 2);
            last_hs = cyc;
            beats++;
          end
        end else if (m_axis_valid) begin
          chk("extra_beat", beats, N - 1);
        end
        prev_stall = m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
        if (!fired && kind != 0 && beats >= at) begin
          fired = 1;
          case (kind)
            1: begin
              wr_en   = 1'b1;
              wr_addr = AW'(5);
              wr_data = ~model_mem[5];
              err_due = 1;
            end
            2: start = 1'b1;
            default: begin
              reset   = 1'b1;
              rst_due = 1;
            end
          endcase
        end
      end
      @(negedge s_axi_aclk);
      cyc++;
    end
    m_axis_ready = 1'b0;
    if (aborted) begin
      // an aborted frame must not report completion
      repeat (6) begin
        chk("no_done_after_abort", 32'(done), 32'd0);
        @(negedge s_axi_aclk);
      end
    end else begin
      chk("done_seen", done_cnt, 1);
      chk("done_one_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(m_axis_valid), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge s_axi_aclk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wr_err", 32'(wr_err), 32'd0);
    chk("reset_valid", 32'(m_axis_valid), 32'd0);
    chk("reset_data", 32'(m_axis_data), 32'd0);
`ifdef PIX_STREAM_TLAST_EN
    chk("reset_last", 32'(m_axis_last), 32'd0);
`endif

    for (int i = 0; i < N; i++) write_word(i, DW'(i), 1'b0);
    write_word(800, 16'hBEEF, 1'b1);

    run_frame(0, 0, 0, 1'b0);   // full frame, no backpressure, exact timing
    run_frame(1, 0, 0, 1'b0);   // ready toggling
    run_frame(0, 1, 2, 1'b0);   // write to addr 5 while busy is dropped
    run_frame(1, 2, 100, 1'b0); // start while busy is ignored
    run_frame(0, 3, 300, 1'b0); // reset mid-stream
    run_frame(0, 0, 0, 1'b0);   // restream from the retained buffer

    for (int i = 0; i < 60; i++) write_word(int'($urandom_range(N - 1)), DW'($urandom), 1'b0);
    run_frame(2, 0, 0, 1'b1);   // random data, random ready, write+start same cycle
    run_frame(2, 1, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
